// File: rtl/pwm_fade_sequencer.sv
// Avalon-MM breathing-ramp generator that drives the PWM compare input.
// Define FADE_IRQ_EN to add the ins_irq port and the irq_pending logic.
module pwm_fade_sequencer #(
  parameter int unsigned TICK_W = 24
) (
  input  logic        csi_clk,
  input  logic        csi_reset,
  input  logic        avs_chipselect,
  input  logic [3:0]  avs_address,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] coe_pwm_compare,
  output logic        coe_compare_update
`ifdef FADE_IRQ_EN
  ,
  output logic        ins_irq
`endif
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StRampUp   = 3'd1,
    StHoldHigh = 3'd2,
    StRampDown = 3'd3,
    StHoldLow  = 3'd4
  } state_e;

  localparam logic [3:0] AddrCtrl    = 4'd0;
  localparam logic [3:0] AddrTickDiv = 4'd1;
  localparam logic [3:0] AddrStep    = 4'd2;
  localparam logic [3:0] AddrMin     = 4'd3;
  localparam logic [3:0] AddrMax     = 4'd4;
  localparam logic [3:0] AddrHold    = 4'd5;
  localparam logic [3:0] AddrStatus  = 4'd6;
  localparam logic [3:0] AddrCur     = 4'd7;

  localparam logic [TICK_W-1:0] TickDivRst = TICK_W'(100000);
  localparam logic [TICK_W-1:0] TickOne    = TICK_W'(1);

  // Configuration registers
  logic              enable_q, enable_d;
  logic              one_shot_q, one_shot_d;
  logic [TICK_W-1:0] tick_div_q, tick_div_d;
  logic [31:0]       step_q, step_d;
  logic [31:0]       min_q, min_d;
  logic [31:0]       max_q, max_d;
  logic [15:0]       hold_q, hold_d;

  // Sequencer state
  state_e            state_q, state_d;
  logic [31:0]       cur_q, cur_d;
  logic              update_q, update_d;
  logic [TICK_W-1:0] presc_q, presc_d;
  logic [15:0]       hold_cnt_q, hold_cnt_d;
  logic [31:0]       readdata_q, readdata_d;

  logic              wr_en, rd_en, ctrl_wr, stop_req;
  logic              tick, cycle_done, irq_pending;
  logic [TICK_W-1:0] tick_div_eff;
  logic [32:0]       sum;
  logic [31:0]       diff;
  logic [16:0]       hold_next;
  logic [31:0]       rd_mux;

  assign wr_en    = avs_chipselect & avs_write;
  // A write in the same cycle as a read suppresses the read.
  assign rd_en    = avs_chipselect & avs_read & ~wr_en;
  assign ctrl_wr  = wr_en && (avs_address == AddrCtrl);
  assign stop_req = ctrl_wr && !avs_writedata[0];

  assign tick_div_eff = (tick_div_q == '0) ? TickOne : tick_div_q;
  // >= keeps the prescaler from running away if TICK_DIV shrinks mid-count.
  assign tick         = (presc_q >= (tick_div_eff - TickOne));
  assign sum          = {1'b0, cur_q} + {1'b0, step_q};
  assign diff         = cur_q - min_q;
  assign hold_next    = {1'b0, hold_cnt_q} + 17'd1;

  always_comb begin
    enable_d   = enable_q;
    one_shot_d = one_shot_q;
    tick_div_d = tick_div_q;
    step_d     = step_q;
    min_d      = min_q;
    max_d      = max_q;
    hold_d     = hold_q;
    if (wr_en) begin
      case (avs_address)
        AddrCtrl: begin
          enable_d   = avs_writedata[0];
          one_shot_d = avs_writedata[1];
        end
        AddrTickDiv: tick_div_d = avs_writedata[TICK_W-1:0];
        AddrStep:    step_d     = avs_writedata;
        AddrMin:     min_d      = avs_writedata;
        AddrMax:     max_d      = avs_writedata;
        AddrHold:    hold_d     = avs_writedata[15:0];
        default: ;
      endcase
    end
    if (cycle_done && one_shot_q && !ctrl_wr) begin
      enable_d = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    presc_d    = presc_q;
    hold_cnt_d = hold_cnt_q;
    cycle_done = 1'b0;
    if (stop_req) begin
      state_d = StIdle;
      presc_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          presc_d = '0;
          if (enable_q) begin
            cur_d      = min_q;
            hold_cnt_d = '0;
            state_d    = StRampUp;
          end
        end
        StRampUp, StHoldHigh, StRampDown, StHoldLow: begin
          presc_d = tick ? '0 : presc_q + TickOne;
          if (tick) begin
            case (state_q)
              StRampUp: begin
                if (sum >= {1'b0, max_q}) begin
                  cur_d      = max_q;
                  hold_cnt_d = '0;
                  state_d    = StHoldHigh;
                end else begin
                  cur_d = sum[31:0];
                end
              end
              StRampDown: begin
                if ((cur_q <= min_q) || (diff <= step_q)) begin
                  cur_d      = min_q;
                  hold_cnt_d = '0;
                  state_d    = StHoldLow;
                end else begin
                  cur_d = cur_q - step_q;
                end
              end
              StHoldHigh: begin
                if (hold_next >= {1'b0, hold_q}) begin
                  state_d = StRampDown;
                end else begin
                  hold_cnt_d = hold_next[15:0];
                end
              end
              StHoldLow: begin
                if (hold_next >= {1'b0, hold_q}) begin
                  cycle_done = 1'b1;
                  state_d    = one_shot_q ? StIdle : StRampUp;
                end else begin
                  hold_cnt_d = hold_next[15:0];
                end
              end
              default: state_d = StIdle;
            endcase
          end
        end
        default: begin
          state_d = StIdle;
          presc_d = '0;
        end
      endcase
    end
  end

  assign update_d = (cur_d != cur_q);

`ifdef FADE_IRQ_EN
  logic irq_pending_q, irq_pending_d;

  // Set beats clear when both land in the same cycle.
  always_comb begin
    irq_pending_d = irq_pending_q;
    if (cycle_done) begin
      irq_pending_d = 1'b1;
    end else if (ctrl_wr && avs_writedata[2]) begin
      irq_pending_d = 1'b0;
    end
  end

  always_ff @(posedge csi_clk) begin
    if (csi_reset) begin
      irq_pending_q <= 1'b0;
    end else begin
      irq_pending_q <= irq_pending_d;
    end
  end

  assign irq_pending = irq_pending_q;
  assign ins_irq     = irq_pending_q;
`else
  assign irq_pending = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      AddrCtrl:    rd_mux = {30'd0, one_shot_q, enable_q};
      AddrTickDiv: rd_mux = 32'(tick_div_q);
      AddrStep:    rd_mux = step_q;
      AddrMin:     rd_mux = min_q;
      AddrMax:     rd_mux = max_q;
      AddrHold:    rd_mux = {16'd0, hold_q};
      AddrStatus:  rd_mux = {27'd0, irq_pending, (state_q != StIdle), state_q};
      AddrCur:     rd_mux = cur_q;
      default:     rd_mux = '0;
    endcase
  end

  assign readdata_d = rd_en ? rd_mux : readdata_q;

  always_ff @(posedge csi_clk) begin
    if (csi_reset) begin
      enable_q   <= 1'b0;
      one_shot_q <= 1'b0;
      tick_div_q <= TickDivRst;
      step_q     <= 32'd10;
      min_q      <= 32'd0;
      max_q      <= 32'd1000;
      hold_q     <= 16'd0;
      state_q    <= StIdle;
      cur_q      <= 32'd0;
      update_q   <= 1'b0;
      presc_q    <= '0;
      hold_cnt_q <= 16'd0;
      readdata_q <= 32'd0;
    end else begin
      enable_q   <= enable_d;
      one_shot_q <= one_shot_d;
      tick_div_q <= tick_div_d;
      step_q     <= step_d;
      min_q      <= min_d;
      max_q      <= max_d;
      hold_q     <= hold_d;
      state_q    <= state_d;
      cur_q      <= cur_d;
      update_q   <= update_d;
      presc_q    <= presc_d;
      hold_cnt_q <= hold_cnt_d;
      readdata_q <= readdata_d;
    end
  end

  assign avs_readdata       = readdata_q;
  assign coe_pwm_compare    = cur_q;
  assign coe_compare_update = update_q;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Self-checking bench for pwm_fade_sequencer: directed scenarios plus random bus traffic
// compared every cycle against a behavioural model.
module tb_pwm_fade_sequencer;

  logic        csi_clk = 1'b0;
  logic        csi_reset = 1'b1;
  logic        avs_chipselect = 1'b0;
  logic [3:0]  avs_address = 4'd0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'd0;
  logic [31:0] coe_pwm_compare;
  logic        coe_compare_update;
`ifdef FADE_IRQ_EN
  logic        ins_irq;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;
  bit wrap_watch = 1'b0;
  bit wrap_seen = 1'b0;
  logic [31:0] upd_q[$];

  always #5 csi_clk = ~csi_clk;

  pwm_fade_sequencer #(.TICK_W(24)) dut (
    .csi_clk           (csi_clk),
    .csi_reset         (csi_reset),
    .avs_chipselect    (avs_chipselect),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_readdata      (avs_readdata),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .coe_pwm_compare   (coe_pwm_compare),
    .coe_compare_update(coe_compare_update)
`ifdef FADE_IRQ_EN
    ,
    .ins_irq           (ins_irq)
`endif
  );

  // Behavioural model: states 0 idle, 1 up, 2 hold high, 3 down, 4 hold low.
  typedef struct packed {
    logic        en;
    logic        os;
    logic [31:0] div;
    logic [31:0] step;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [31:0] hold;
    logic [31:0] cur;
    logic [31:0] presc;
    logic [31:0] hcnt;
    logic [31:0] rd;
    logic [2:0]  st;
    logic        irq;
    logic        upd;
  } model_t;

  model_t m;

  function automatic model_t model_step(model_t s, logic rst, logic cs, logic rd, logic wr,
                                        logic [3:0] a, logic [31:0] wd);
    model_t n = s;
    logic w = cs & wr;
    logic r = cs & rd & ~(cs & wr);
    logic done = 1'b0;
    logic tick;
    logic [63:0] div;
    if (rst) begin
      n = '0;
      n.div = 32'd100000;
      n.step = 32'd10;
      n.hi = 32'd1000;
      return n;
    end
    if (w) begin
      case (a)
        4'd0: begin n.en = wd[0]; n.os = wd[1]; end
        4'd1: n.div = {8'd0, wd[23:0]};
        4'd2: n.step = wd;
        4'd3: n.lo = wd;
        4'd4: n.hi = wd;
        4'd5: n.hold = {16'd0, wd[15:0]};
        default: ;
      endcase
    end
    if (w && a == 4'd0 && !wd[0]) begin
      n.st = 3'd0;
      n.presc = 0;
    end else if (s.st == 3'd0) begin
      n.presc = 0;
      if (s.en) begin
        n.cur = s.lo;
        n.st = 3'd1;
        n.hcnt = 0;
      end
    end else begin
      div = (s.div == 0) ? 64'd1 : {32'd0, s.div};
      tick = ({32'd0, s.presc} + 64'd1) >= div;
      n.presc = tick ? 32'd0 : s.presc + 32'd1;
      if (tick) begin
        case (s.st)
          3'd1: begin
            if ({32'd0, s.cur} + {32'd0, s.step} >= {32'd0, s.hi}) begin
              n.cur = s.hi; n.st = 3'd2; n.hcnt = 0;
            end else begin
              n.cur = s.cur + s.step;
            end
          end
          3'd2: begin
            n.hcnt = s.hcnt + 1;
            if (n.hcnt >= s.hold) n.st = 3'd3;
          end
          3'd3: begin
            if (s.cur <= s.lo || (s.cur - s.lo) <= s.step) begin
              n.cur = s.lo; n.st = 3'd4; n.hcnt = 0;
            end else begin
              n.cur = s.cur - s.step;
            end
          end
          default: begin
            n.hcnt = s.hcnt + 1;
            if (n.hcnt >= s.hold) begin
              done = 1'b1;
              if (s.os) begin
                n.st = 3'd0;
                if (!(w && a == 4'd0)) n.en = 1'b0;
              end else begin
                n.st = 3'd1;
              end
            end
          end
        endcase
      end
    end
`ifdef FADE_IRQ_EN
    if (done) n.irq = 1'b1;
    else if (w && a == 4'd0 && wd[2]) n.irq = 1'b0;
`else
    n.irq = 1'b0;
`endif
    if (r) begin
      case (a)
        4'd0: n.rd = {30'd0, s.os, s.en};
        4'd1: n.rd = s.div;
        4'd2: n.rd = s.step;
        4'd3: n.rd = s.lo;
        4'd4: n.rd = s.hi;
        4'd5: n.rd = s.hold;
        4'd6: n.rd = {27'd0, s.irq, (s.st != 3'd0), s.st};
        4'd7: n.rd = s.cur;
        default: n.rd = 32'd0;
      endcase
    end
    n.upd = (n.cur != s.cur);
    return n;
  endfunction

  always @(posedge csi_clk) begin
    m <= model_step(m, csi_reset, avs_chipselect, avs_read, avs_write, avs_address,
                    avs_writedata);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge csi_clk) begin
    if (chk_on) begin
      check("compare", coe_pwm_compare, m.cur);
      check("update", {31'd0, coe_compare_update}, {31'd0, m.upd});
      check("readdata", avs_readdata, m.rd);
`ifdef FADE_IRQ_EN
      check("irq", {31'd0, ins_irq}, {31'd0, m.irq});
`endif
      if (coe_compare_update) upd_q.push_back(coe_pwm_compare);
      if (wrap_watch && coe_pwm_compare > 32'd1000) wrap_seen = 1'b1;
    end
  end

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    avs_chipselect = 1'b1; avs_write = 1'b1; avs_address = a; avs_writedata = d;
    @(negedge csi_clk);
    avs_chipselect = 1'b0; avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = a;
    @(negedge csi_clk);
    avs_chipselect = 1'b0; avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic bus_rw(input logic [3:0] a, input logic [31:0] d);
    avs_chipselect = 1'b1; avs_read = 1'b1; avs_write = 1'b1;
    avs_address = a; avs_writedata = d;
    @(negedge csi_clk);
    avs_chipselect = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
  endtask

  task automatic do_reset();
    csi_reset = 1'b1;
    @(negedge csi_clk);
    csi_reset = 1'b0;
  endtask

  task automatic wait_updates(input int n, input int budget);
    int c = 0;
    while (upd_q.size() < n && c < budget) begin
      @(negedge csi_clk);
      c++;
    end
  endtask

  task automatic config_ramp(input int hold, input logic [31:0] lo, input logic [31:0] hi,
                             input logic [31:0] step);
    bus_write(4'd1, 32'd2);
    bus_write(4'd2, step);
    bus_write(4'd3, lo);
    bus_write(4'd4, hi);
    bus_write(4'd5, hold);
  endtask

  logic [31:0] rd;
  int exp_rst[10] = '{0, 100000, 10, 0, 1000, 0, 0, 0, 0, 0};
  int rst_addr[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 15};
  int exp_seq[8] = '{300, 600, 900, 1000, 700, 400, 100, 0};
  int exp_inv[3] = '{500, 200, 500};

  initial begin
    repeat (2) @(negedge csi_clk);
    chk_on = 1'b1;
    csi_reset = 1'b0;

    // Reset values
    for (int i = 0; i < 10; i++) begin
      bus_read(4'(rst_addr[i]), rd);
      check($sformatf("reset_reg%0d", rst_addr[i]), rd, exp_rst[i]);
    end
    check("reset_compare", coe_pwm_compare, 32'd0);

    // Continuous ramp sequence
    config_ramp(1, 32'd0, 32'd1000, 32'd300);
    upd_q.delete();
    bus_write(4'd0, 32'd1);
    wait_updates(8, 400);
    check("seq_count", {31'd0, upd_q.size() >= 8}, 32'd1);
    if (upd_q.size() >= 8) begin
      for (int i = 0; i < 8; i++) check($sformatf("seq%0d", i), upd_q[i], exp_seq[i]);
    end

    // One-shot
    do_reset();
    config_ramp(1, 32'd0, 32'd1000, 32'd300);
    bus_write(4'd0, 32'd3);
    repeat (60) @(negedge csi_clk);
    bus_read(4'd0, rd);
    check("oneshot_ctrl", rd, 32'd2);
    bus_read(4'd6, rd);
`ifdef FADE_IRQ_EN
    check("oneshot_status", rd, 32'h10);
    check("oneshot_irq", {31'd0, ins_irq}, 32'd1);
    bus_write(4'd0, 32'd4);
    check("irq_cleared", {31'd0, ins_irq}, 32'd0);
`else
    check("oneshot_status", rd, 32'h0);
`endif

    // MAX below MIN
    do_reset();
    config_ramp(0, 32'd500, 32'd200, 32'd10);
    upd_q.delete();
    wrap_seen = 1'b0;
    wrap_watch = 1'b1;
    bus_write(4'd0, 32'd1);
    wait_updates(3, 200);
    check("inv_count", {31'd0, upd_q.size() >= 3}, 32'd1);
    if (upd_q.size() >= 3) begin
      for (int i = 0; i < 3; i++) check($sformatf("inv%0d", i), upd_q[i], exp_inv[i]);
    end
    repeat (40) @(negedge csi_clk);
    wrap_watch = 1'b0;
    check("no_wrap", {31'd0, wrap_seen}, 32'd0);

    // Disable mid-ramp, then restart from MIN
    do_reset();
    config_ramp(0, 32'd50, 32'd1000, 32'd300);
    bus_write(4'd0, 32'd1);
    repeat (6) @(negedge csi_clk);
    bus_write(4'd0, 32'd0);
    bus_read(4'd6, rd);
    check("stop_status", rd, 32'd0);
    repeat (10) @(negedge csi_clk);
    check("stop_frozen", coe_pwm_compare, 32'd650);
    bus_write(4'd0, 32'd1);
    check("restart_hold", coe_pwm_compare, 32'd650);
    @(negedge csi_clk);
    check("restart_min", coe_pwm_compare, 32'd50);
    bus_read(4'd6, rd);
    check("restart_status", rd, 32'd9);

    // Reset during HOLD_HIGH
    do_reset();
    config_ramp(20, 32'd0, 32'd1000, 32'd300);
    bus_write(4'd0, 32'd1);
    for (int c = 0; c < 200 && m.st != 3'd2; c++) @(negedge csi_clk);
    check("reached_hold_high", {29'd0, m.st}, 32'd2);
    repeat (3) @(negedge csi_clk);
    do_reset();
    check("rst_compare", coe_pwm_compare, 32'd0);
    check("rst_update", {31'd0, coe_compare_update}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      bus_read(4'(rst_addr[i]), rd);
      check($sformatf("rst_mid_reg%0d", i), rd, exp_rst[i]);
    end

    // Random traffic against the model
    for (int it = 0; it < 1500; it++) begin
      int op;
      op = $urandom_range(0, 99);
      if (op < 8) bus_write(4'd0, 32'($urandom_range(0, 7)) | 32'd1);
      else if (op < 10) bus_write(4'd0, 32'($urandom_range(0, 7)));
      else if (op < 14) bus_write(4'd1, 32'($urandom_range(0, 4)));
      else if (op < 20) bus_write(4'd2, ($urandom_range(0, 3) == 0) ? $urandom
                                                                 : 32'($urandom_range(0, 400)));
      else if (op < 26) bus_write(4'd3, ($urandom_range(0, 5) == 0) ? $urandom
                                                                 : 32'($urandom_range(0, 1500)));
      else if (op < 32) bus_write(4'd4, ($urandom_range(0, 5) == 0) ? $urandom
                                                                 : 32'($urandom_range(0, 2000)));
      else if (op < 36) bus_write(4'd5, 32'($urandom_range(0, 3)));
      else if (op < 38) bus_write(4'($urandom_range(8, 15)), $urandom);
      else if (op < 41) bus_rw(4'($urandom_range(0, 15)), $urandom & 32'hFFFF_FFFB);
      else if (op < 42) do_reset();
      else if (op < 62) bus_read(4'($urandom_range(0, 15)), rd);
      else repeat ($urandom_range(1, 3)) @(negedge csi_clk);
    end

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
